// File: rtl/flipflop_pkg.sv
// Shared definitions for the toggle-line decoder: frame state encoding and
// the default word width.
package flipflop_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Framing states. The encoding is fixed so that state values seen in
  // waveforms match across every block that imports this package.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage : flipflop_pkg

// File: rtl/t_word_fifo.sv
// Two-entry word buffer between the frame decoder and the consumer.
// It is built as a head/tail pair rather than a pointer-addressed array, so
// the head word and its valid flag are driven straight from flops. A word
// leaving the head moves the tail forward, and a push lands in the first
// free slot after any pop in the same cycle.
module t_word_fifo
  import flipflop_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             head_v_q, head_v_d;
  logic             tail_v_q, tail_v_d;
  logic             pop_eff;
  logic             accept;

  assign full    = head_v_q & tail_v_q;
  assign empty   = ~head_v_q;
  assign head    = head_q;
  // A pop is only meaningful with a word at the head.
  assign pop_eff = pop & head_v_q;
  // When full, a push is taken only if the head leaves in the same cycle.
  assign accept  = push & (~full | pop_eff);

  // Next-state of the two slots: apply the pop first, then place the push.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    head_d   = head_q;
    head_v_d = head_v_q;
    tail_d   = tail_q;
    tail_v_d = tail_v_q;
    if (pop_eff) begin
      head_d   = tail_q;
      head_v_d = tail_v_q;
      tail_d   = '0;
      tail_v_d = 1'b0;
    end
    if (accept) begin
      if (!head_v_d) begin
        head_d   = push_data;
        head_v_d = 1'b1;
      end else begin
        tail_d   = push_data;
        tail_v_d = 1'b1;
      end
    end
  end

  // Slot registers; empty slots always hold zero so the head reads 0 when empty.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only two words of storage, so the slots are reset like ordinary
    // flops; this is what guarantees a zero head word straight out of reset.
    if (rst) begin
      head_q   <= '0;
      head_v_q <= 1'b0;
      tail_q   <= '0;
      tail_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      head_v_q <= head_v_d;
      tail_q   <= tail_d;
      tail_v_q <= tail_v_d;
    end
  end

endmodule : t_word_fifo

// File: rtl/t_stream_decoder.sv
// Receive-side decoder for a T-flip-flop driven serial line. Each strobed
// sample is compared with the previous one to recover the transmitted bit,
// bits are framed as start / WIDTH data bits (LSB first) / stop, and good
// words are queued in a two-entry buffer read through valid/ready.
module t_stream_decoder
  import flipflop_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             Q,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             FERR,
  output logic             OVR,
  output logic             BUSY
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_FINAL = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             q_prev;
  logic             t_bit;
  logic             push_word;
  logic             ferr_d;
  logic             ovr_d;
  logic             pop;
  logic             full;
  logic             empty;

  // Recovered bit: the line toggles exactly when a 1 was sent.
  assign t_bit = Q ^ q_prev;

  // Previous line sample, advanced only on strobe cycles. Resets to 0 to
  // match the transmitter flip-flop's own reset value.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values, independent of block ordering.
    if (RST) q_prev <= 1'b0;
    else if (EN) q_prev <= Q;
  end

  // Framing state, bit counter and shift register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; nothing moves on cycles without a strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push_word = 1'b0;
    ferr_d    = 1'b0;
    if (EN) begin
      unique case (state_q)
        HUNT: begin
          if (t_bit) begin
            cnt_d   = '0;
            shift_d = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          // LSB arrives first, so after WIDTH shifts it sits in bit 0.
          shift_d = {t_bit, shift_q[WIDTH-1:1]};
          cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
          if (cnt_q == CNT_FINAL) state_d = STOP;
        end
        STOP: begin
          // A 1 here is a framing error and is consumed, not taken as a start.
          if (t_bit) ferr_d    = 1'b1;
          else       push_word = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign pop   = DOUT_VALID & DOUT_READY;
  // A completed word is lost only when no slot is free and none frees up.
  assign ovr_d = push_word & full & ~pop;

  // One-cycle error pulses, registered off the stop-bit edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FERR <= 1'b0;
      OVR  <= 1'b0;
    end else begin
      FERR <= ferr_d;
      OVR  <= ovr_d;
    end
  end

  t_word_fifo #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push_word),
    .push_data(shift_q),
    .pop      (pop),
    .head     (DOUT),
    .full     (full),
    .empty    (empty)
  );

  assign DOUT_VALID = ~empty;
  assign BUSY       = (state_q == DATA) || (state_q == STOP);

endmodule : t_stream_decoder

// File: tb/tb_t_stream_decoder.sv
// Directed bench for t_stream_decoder. A scoreboard queue receives each word
// expected to reach the consumer when its frame is driven; a monitor pops and
// compares on every accepted output transfer.
module tb_t_stream_decoder;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             Q = 1'b0;
  logic [WIDTH-1:0] DOUT;
  logic             DOUT_VALID;
  logic             DOUT_READY = 1'b1;
  logic             FERR;
  logic             OVR;
  logic             BUSY;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] sb[$];
  logic             q_line = 1'b0;   // model of the transmitter flip-flop

  t_stream_decoder #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .Q         (Q),
    .DOUT      (DOUT),
    .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY),
    .FERR      (FERR),
    .OVR       (OVR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: inputs change just after posedge, so the negedge
  // sees exactly the valid/ready pair the next posedge will act on.
  always @(negedge CLK) begin
    if (!RST && DOUT_VALID && DOUT_READY) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $error("FAIL sb_unexpected observed=%0h expected=none", DOUT);
      end else begin
        logic [WIDTH-1:0] exp_w;
        exp_w = sb.pop_front();
        assert (DOUT === exp_w) else begin
          mismatched++;
          $error("FAIL sb_word observed=%0h expected=%0h", DOUT, exp_w);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    EN     = 1'b0;
    q_line = 1'b0;
    Q      = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    step();
  endtask

  // One strobed bit, then 'gap' idle cycles with the line held.
  task automatic send_bit(input logic b, input int gap, input logic exp_busy);
    EN = 1'b1;
    if (b) q_line = ~q_line;
    Q = q_line;
    step();
    check("busy_after_bit", BUSY, exp_busy);
    EN = 1'b0;
    for (int g = 0; g < gap; g++) begin
      step();
      check("busy_hold", BUSY, exp_busy);
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop_bit,
                            input logic expect_word, input logic rdy_stop, input int gap);
    send_bit(1'b1, gap, 1'b1);
    for (int i = 0; i < WIDTH; i++) send_bit(data[i], gap, 1'b1);
    if (expect_word) sb.push_back(data);
    DOUT_READY = rdy_stop;
    send_bit(stop_bit, gap, 1'b0);
  endtask

  task automatic drain();
    DOUT_READY = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !DOUT_VALID) break;
      step();
    end
    check("drain_left", sb.size(), 0);
    check("drain_valid", DOUT_VALID, 1'b0);
  endtask

  initial begin
    // Reset values.
    do_reset();
    check("rst_dout", DOUT, 8'h00);
    check("rst_valid", DOUT_VALID, 1'b0);
    check("rst_ferr", FERR, 1'b0);
    check("rst_ovr", OVR, 1'b0);
    check("rst_busy", BUSY, 1'b0);

    // Good frame 0xA5: word visible right after the stop edge.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 0);
    check("a5_valid", DOUT_VALID, 1'b1);
    check("a5_dout", DOUT, 8'hA5);
    check("a5_ferr", FERR, 1'b0);
    step();
    check("a5_popped", DOUT_VALID, 1'b0);

    // Bad stop bit: FERR for one cycle, nothing buffered.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0);
    check("ferr_pulse", FERR, 1'b1);
    check("ferr_valid", DOUT_VALID, 1'b0);
    check("ferr_busy", BUSY, 1'b0);
    step();
    check("ferr_clear", FERR, 1'b0);

    // Stalled consumer: third word overflows.
    DOUT_READY = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 0);
    check("ovr_pulse", OVR, 1'b1);
    check("ovr_head", DOUT, 8'h11);
    check("ovr_valid", DOUT_VALID, 1'b1);
    step();
    check("ovr_clear", OVR, 1'b0);
    drain();

    // Full buffer with a pop on the stop edge: no overflow.
    DOUT_READY = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h66, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h44, 1'b0, 1'b1, 1'b1, 0);
    check("pushpop_ovr", OVR, 1'b0);
    check("pushpop_head", DOUT, 8'h66);
    drain();

    // Reset in the middle of a frame, then a clean frame.
    send_bit(1'b1, 0, 1'b1);
    send_bit(1'b1, 0, 1'b1);
    send_bit(1'b0, 0, 1'b1);
    do_reset();
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_valid", DOUT_VALID, 1'b0);
    check("midrst_ferr", FERR, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 0);
    check("5a_ferr", FERR, 1'b0);
    drain();

    // Strobe every third cycle.
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 2);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule : tb_t_stream_decoder

// File: doc/t_stream_decoder.md
# t_stream_decoder

Receive-side decoder for a toggle-encoded serial line driven by a T flip-flop, where the line toggles on each clock-enable where the transmitted bit is 1. It recovers each bit as the current line value XOR the previous line value, then frames the bits as start, WIDTH data bits (LSB first) and stop. Completed words go into a 2-entry buffer read through a valid/ready handshake. It sits on the far end of the toggle line and hands words to downstream logic.

## Interface
- WIDTH, 8: data bits per frame (2..16).
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  bit strobe; the line is sampled only on cycles with EN=1.
- Q  input  1  toggle-encoded line (flip-flop output), synchronous to CLK.
- DOUT  output  WIDTH  head-of-buffer word; 0 when empty.
- DOUT_VALID  output  1  buffer non-empty.
- DOUT_READY  input  1  consumer accepts DOUT when DOUT_VALID=1.
- FERR  output  1  one-cycle pulse: stop bit decoded as 1; the word is dropped.
- OVR  output  1  one-cycle pulse: word completed while the buffer was full with no pop; the word is dropped.
- BUSY  output  1  high in the DATA and STOP states.

## Operation
- Bit recovery, on EN cycles only: t = Q ^ q_prev, then q_prev <= Q. Reset value of q_prev is 0, matching the flip-flop reset value.
- State machine, advancing only on EN=1:
  - HUNT: t=1 is the start bit; clear bit count and shift register, go to DATA. t=0 stays in HUNT.
  - DATA: shift t into bit[cnt], LSB first; cnt++. After WIDTH bits go to STOP.
  - STOP: t=0 pushes the word and goes to HUNT. t=1 pulses FERR, pushes nothing and goes to HUNT; that 1 is not reused as a start bit.
- Counter width: clog2(WIDTH+1). cnt saturates logically at WIDTH; no wrap inside a frame.
- Buffer: 2 entries. Pop happens when DOUT_VALID && DOUT_READY. Push when full with a simultaneous pop succeeds. Push when full without a pop pulses OVR, drops the new word and keeps the buffer contents.
- EN=0 cycles hold all state; DOUT_READY is still honoured.
- Reset mid-frame or mid-buffer: return to HUNT, empty the buffer, q_prev=0, no FERR/OVR pulse.
- Reset values: DOUT=0, DOUT_VALID=0, FERR=0, OVR=0, BUSY=0.

## Timing
- DOUT_VALID rises in the cycle after the CLK edge that samples a good stop bit. Latency is 1 cycle from the stop-bit EN.
- FERR and OVR are registered and assert for exactly one cycle after the offending stop-bit edge.
- DOUT and DOUT_VALID are registered. The next entry appears the cycle after a pop. Pushing into the empty buffer while popping is not possible, since a pop requires non-empty.
- Throughput: one word per WIDTH+2 EN strobes. The consumer may stall up to 2 words without loss.
- Back-to-back frames: a start bit on the EN immediately after STOP is accepted.

## Structure
- Shared package flipflop_pkg holds the state encoding (HUNT=2'd0, DATA=2'd1, STOP=2'd2) and the default WIDTH constant.
- Sub-module t_word_fifo holds the 2-entry buffer: push, pop, full, empty, head data, parameterised on WIDTH.
- The top level holds bit recovery, the state machine and the shift register.

## Test plan
- Reset, then EN every cycle with Q toggling on a frame of 0xA5 (start 1, data 1,0,1,0,0,1,0,1, stop 0) -> DOUT=0xA5, DOUT_VALID=1 one cycle after the stop edge, FERR=0.
- Same frame but stop t=1 -> FERR pulses one cycle, DOUT_VALID stays 0, BUSY=0 afterwards.
- DOUT_READY=0, send 0x11, 0x22, 0x33 -> buffer holds 0x11 and 0x22, OVR pulses on the 0x33 stop; then the consumer reads 0x11 then 0x22.
- Buffer full and DOUT_READY=1 on the stop edge of 0x44 -> no OVR; the output sequence continues with 0x44 after the existing entries.
- Assert RST during the DATA bits of a frame, then send 0x5A -> only 0x5A is output; no partial word, no FERR.
- EN strobing every 3rd cycle with Q held between strobes, send 0xFF then 0x00 -> outputs 0xFF, 0x00; state unchanged on EN=0 cycles.
